qpu_dmem_icb_slv: RTL

QPU_DMEM_ICB_SLV -- requirements
Module: qpu_dmem_icb_slv

---
 rtl/qpu_dmem_icb_slv_pkg.sv | 33 +++
 rtl/qpu_dmem_icb_slv_if.sv | 29 ++
 rtl/qpu_dmem_rsp_fifo.sv | 83 ++++++++
 rtl/qpu_dmem_icb_slv.sv | 85 ++++++++
 4 files changed

// File: rtl/qpu_dmem_icb_slv_pkg.sv
// Shared QPU constants (XLEN, address size, default data-memory depth) and ICB data-memory types.
// Optional feature macro used by this slice: QPU_DMEM_RANGE_CHK_EN.
package qpu_dmem_icb_slv_pkg;

    localparam int QPU_XLEN       = 32;
    localparam int QPU_ADDR_SIZE  = 32;
    localparam int QPU_DMEM_DEPTH = 256;
    localparam int QPU_WMASK_W    = QPU_XLEN / 8;

    typedef struct packed {
        logic [QPU_XLEN-1:0] rdata;
        logic                err;
    } dmem_rsp_t;

    // Byte-granular merge: bytes whose mask bit is set come from new_word.
    function automatic logic [QPU_XLEN-1:0] merge_bytes(
        input logic [QPU_XLEN-1:0]    old_word,
        input logic [QPU_XLEN-1:0]    new_word,
        input logic [QPU_WMASK_W-1:0] mask
    );
        logic [QPU_XLEN-1:0] res;
        res = old_word;
        for (int i = 0; i < QPU_WMASK_W; i++) begin
            if (mask[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/qpu_dmem_icb_slv_if.sv
// ICB command/response bundle between a bus master and the data-memory slave.
// Optional feature macro in this slice: QPU_DMEM_RANGE_CHK_EN (not used here).
interface qpu_dmem_icb_slv_if;
    import qpu_dmem_icb_slv_pkg::*;

    logic                     icb_cmd_valid;
    logic                     icb_cmd_ready;
    logic [QPU_ADDR_SIZE-1:0] icb_cmd_addr;
    logic                     icb_cmd_read;
    logic [QPU_XLEN-1:0]      icb_cmd_wdata;
    logic [QPU_WMASK_W-1:0]   icb_cmd_wmask;
    logic                     icb_rsp_valid;
    logic                     icb_rsp_ready;
    logic [QPU_XLEN-1:0]      icb_rsp_rdata;
    logic                     icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

endinterface

// File: rtl/qpu_dmem_rsp_fifo.sv
// Two-entry in-order response buffer (rdata + err); head forced to zero while empty.
// Optional feature macro in this slice: QPU_DMEM_RANGE_CHK_EN (not used here).
module qpu_dmem_rsp_fifo
    import qpu_dmem_icb_slv_pkg::*;
#(
    parameter int RSP_DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  dmem_rsp_t push_data_i,
    input  logic      pop_i,
    output logic      not_full_o,
    output logic      valid_o,
    output dmem_rsp_t head_o
);

    localparam logic [1:0] RSP_CNT = 2'(RSP_DEPTH);

    dmem_rsp_t  ent_q [2];
    dmem_rsp_t  ent_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;

    assign valid_o    = (cnt_q != 2'd0);
    assign not_full_o = (cnt_q < RSP_CNT);

    // Next-state for entries, pointers and occupancy.
    always_comb begin
        ent_d[0] = ent_q[0];
        ent_d[1] = ent_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) begin
            ent_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Head entry presented to the bus; zero when nothing is pending.
    always_comb begin
        head_o = {$bits(dmem_rsp_t){1'b0}};
        if (valid_o) begin
            head_o = ent_q[rd_ptr_q];
        end else begin
            head_o = {$bits(dmem_rsp_t){1'b0}};
        end
    end

    // Control state; synchronous reset discards anything pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload storage; contents only matter while counted as occupied.
    always_ff @(posedge clk) begin
        ent_q[0] <= ent_d[0];
        ent_q[1] <= ent_d[1];
    end

endmodule

// File: rtl/qpu_dmem_icb_slv.sv
// ICB slave wrapping a word-organised data memory with byte write masks and a 2-entry response buffer.
// Define QPU_DMEM_RANGE_CHK_EN to flag out-of-range addresses instead of wrapping them.
module qpu_dmem_icb_slv
    import qpu_dmem_icb_slv_pkg::*;
#(
    parameter int DEPTH     = QPU_DMEM_DEPTH,
    parameter int RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    qpu_dmem_icb_slv_if.slave  icb
);

    localparam int AW = $clog2(DEPTH);
    localparam longint unsigned ADDR_LIMIT = longint'(DEPTH) * 64'd4;

    logic [QPU_XLEN-1:0] mem_q [DEPTH];

    logic                cmd_hsk_s;
    logic                rsp_hsk_s;
    logic [AW-1:0]       idx_s;
    logic                range_err_s;
    logic                wr_en_d;
    logic [QPU_XLEN-1:0] wr_word_d;
    dmem_rsp_t           push_data_s;
    dmem_rsp_t           head_s;
    logic                not_full_s;
    logic                rsp_valid_s;
    logic                unused_s;

    assign idx_s     = icb.icb_cmd_addr[AW+1:2];
    assign cmd_hsk_s = icb.icb_cmd_valid & not_full_s;
    assign rsp_hsk_s = rsp_valid_s & icb.icb_rsp_ready;
    assign unused_s  = ^{icb.icb_cmd_addr[1:0], icb.icb_cmd_addr[QPU_ADDR_SIZE-1:AW+2]};

`ifdef QPU_DMEM_RANGE_CHK_EN
    assign range_err_s = (64'(icb.icb_cmd_addr) >= ADDR_LIMIT);
`else
    assign range_err_s = 1'b0;
`endif

    // Write path and response payload; read data is the pre-write word.
    always_comb begin
        wr_en_d     = 1'b0;
        wr_word_d   = merge_bytes(mem_q[idx_s], icb.icb_cmd_wdata, icb.icb_cmd_wmask);
        push_data_s = {$bits(dmem_rsp_t){1'b0}};
        if (cmd_hsk_s && !icb.icb_cmd_read && !range_err_s && rst_n) begin
            wr_en_d = 1'b1;
        end else begin
            wr_en_d = 1'b0;
        end
        push_data_s.err = range_err_s;
        if (icb.icb_cmd_read && !range_err_s) begin
            push_data_s.rdata = mem_q[idx_s];
        end else begin
            push_data_s.rdata = {QPU_XLEN{1'b0}};
        end
    end

    // Storage array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_d) begin
            mem_q[idx_s] <= wr_word_d;
        end
    end

    qpu_dmem_rsp_fifo #(
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (cmd_hsk_s),
        .push_data_i (push_data_s),
        .pop_i       (rsp_hsk_s),
        .not_full_o  (not_full_s),
        .valid_o     (rsp_valid_s),
        .head_o      (head_s)
    );

    assign icb.icb_cmd_ready = not_full_s;
    assign icb.icb_rsp_valid = rsp_valid_s;
    assign icb.icb_rsp_rdata = head_s.rdata;
    assign icb.icb_rsp_err   = head_s.err;

endmodule
